// File: rtl/asc_pkg.sv
// Shared types and constants for the ASC scan-chain path.
package asc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StShift,
    StUpdate,
    StResp
  } asc_state_e;

  localparam logic [7:0] ASC_ACK          = 8'h01;
  localparam logic [7:0] ASC_NACK_TIMEOUT = 8'hEE;

  function automatic int unsigned packet_bits(input int unsigned addr_bits,
                                              input int unsigned payload_bits);
    return addr_bits + payload_bits;
  endfunction

  function automatic int unsigned packet_bytes(input int unsigned addr_bits,
                                               input int unsigned payload_bits);
    return (addr_bits + payload_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/scan_clk_gen.sv
// Divided scan clock: toggles every Half enabled cycles, idles low when disabled.
module scan_clk_gen #(
  parameter int unsigned Half = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic scan_clk_o,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Half - 1);

  logic [CntW-1:0] cnt_q;
  logic            scan_clk_q;
  logic            half_done;

  // Strobes mark the clk edge on which scan_clk changes level.
  assign half_done   = en_i && (cnt_q == CntLast);
  assign rise_tick_o = half_done && !scan_clk_q;
  assign fall_tick_o = half_done && scan_clk_q;
  assign scan_clk_o  = scan_clk_q;

  // Half-period counter; disable restarts the phase with scan_clk low.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q      <= '0;
      scan_clk_q <= 1'b0;
    end else if (half_done) begin
      cnt_q      <= '0;
      scan_clk_q <= ~scan_clk_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/asc_scan_shifter.sv
// Collects one scan packet from the byte stream, shifts it onto the scan chain,
// pulses update and returns a status byte.
module asc_scan_shifter
  import asc_pkg::*;
#(
  parameter int unsigned CLKS_PER_SCAN_CLK = 100_000,
  parameter int unsigned ADDR_BITS         = 12,
  parameter int unsigned PAYLOAD_BITS      = 160,
  parameter int unsigned TIMEOUT_CLKS      = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [7:0] data_in,
  output logic       response_valid,
  input  logic       response_ready,
  output logic [7:0] response_data,
  output logic       scan_clk,
  output logic       scan_en,
  output logic       scan_in,
  output logic       scan_reset
);

  localparam int unsigned Half        = CLKS_PER_SCAN_CLK / 2;
  localparam int unsigned PacketBits  = packet_bits(ADDR_BITS, PAYLOAD_BITS);
  localparam int unsigned PacketBytes = packet_bytes(ADDR_BITS, PAYLOAD_BITS);
  localparam int unsigned BitCntMax   = (PacketBits > Half) ? PacketBits : Half;
  localparam int unsigned BitCntW     = $clog2(BitCntMax + 1);
  localparam int unsigned ByteCntW    = $clog2(PacketBytes + 1);
  localparam int unsigned TmoW        = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BitCntW-1:0]  BitCntAll = BitCntW'(PacketBits);
  localparam logic [BitCntW-1:0]  HalfLast  = BitCntW'(Half - 1);
  localparam logic [ByteCntW-1:0] LastByte  = ByteCntW'(PacketBytes - 1);
  localparam logic [TmoW-1:0]     TmoLast   = TmoW'(TIMEOUT_CLKS - 1);

  asc_state_e                 state_q;
  logic [PacketBytes*8-1:0]   pkt_q;
  logic [BitCntW-1:0]         bit_cnt_q;
  logic [ByteCntW-1:0]        byte_cnt_q;
  logic [TmoW-1:0]            tmo_q;
  logic                       rdy_q;
  logic                       upd_fell_q;
  logic                       scan_en_q;
  logic                       scan_in_q;
  logic                       scan_reset_q;
  logic                       resp_valid_q;
  logic [7:0]                 resp_data_q;

  logic clk_en;
  logic fall_tick;
  logic rise_tick;
  logic byte_hs;

  // Scan clock runs through SHIFT and UPDATE until the update pulse has fallen.
  assign clk_en  = (state_q == StShift) || ((state_q == StUpdate) && !upd_fell_q);
  assign byte_hs = data_valid && rdy_q;

  scan_clk_gen #(
    .Half (Half)
  ) u_scan_clk_gen (
    .clk_i       (clk),
    .rst_i       (reset),
    .en_i        (clk_en),
    .scan_clk_o  (scan_clk),
    .fall_tick_o (fall_tick),
    .rise_tick_o (rise_tick)
  );

  // Packet FSM with registered outputs and counters.
  always_ff @(posedge clk) begin
    scan_reset_q <= reset;
    if (reset) begin
      state_q      <= StIdle;
      pkt_q        <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      rdy_q        <= 1'b1;
      upd_fell_q   <= 1'b0;
      scan_en_q    <= 1'b0;
      scan_in_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (byte_hs) begin
            pkt_q[7:0] <= data_in;
            byte_cnt_q <= ByteCntW'(1);
            state_q    <= StRecv;
          end
        end
        StRecv: begin
          if (byte_hs) begin
            pkt_q[{byte_cnt_q, 3'b000} +: 8] <= data_in;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            tmo_q      <= '0;
            if (byte_cnt_q == LastByte) begin
              // Bit 0 sits in byte 0, already stored; present it straight away.
              state_q    <= StShift;
              rdy_q      <= 1'b0;
              scan_en_q  <= 1'b1;
              scan_in_q  <= pkt_q[0];
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
            end
          end else if (tmo_q == TmoLast) begin
            state_q      <= StResp;
            rdy_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= ASC_NACK_TIMEOUT;
            byte_cnt_q   <= '0;
            tmo_q        <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StShift: begin
          // Count a bit when the chip samples it; advance data on the falling edge.
          if (rise_tick) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else if (fall_tick) begin
            if (bit_cnt_q == BitCntAll) begin
              state_q    <= StUpdate;
              scan_en_q  <= 1'b0;
              scan_in_q  <= 1'b0;
              bit_cnt_q  <= '0;
              upd_fell_q <= 1'b0;
            end else begin
              scan_in_q <= pkt_q[1];
              pkt_q     <= pkt_q >> 1;
            end
          end
        end
        StUpdate: begin
          // Low, high, then a trailing low half counted with the idle bit counter.
          if (!upd_fell_q) begin
            if (fall_tick) begin
              upd_fell_q <= 1'b1;
            end
          end else if (bit_cnt_q == HalfLast) begin
            state_q      <= StResp;
            upd_fell_q   <= 1'b0;
            bit_cnt_q    <= '0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= ASC_ACK;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (response_ready) begin
            resp_valid_q <= 1'b0;
            rdy_q        <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is masked while reset is held so nothing is accepted during reset.
  assign data_ready     = rdy_q && !reset;
  assign response_valid = resp_valid_q;
  assign response_data  = resp_data_q;
  assign scan_en        = scan_en_q;
  assign scan_in        = scan_in_q;
  assign scan_reset     = scan_reset_q;

endmodule

// File: tb/tb_asc_scan_shifter.sv
// Self-checking bench for asc_scan_shifter with a short scan clock and timeout.
module tb_asc_scan_shifter;

  localparam int NBits   = 172;
  localparam int NBytes  = 22;
  localparam int Clks    = 4;
  localparam int Timeout = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       response_ready = 1'b0;
  logic       data_ready;
  logic       response_valid;
  logic [7:0] response_data;
  logic       scan_clk;
  logic       scan_en;
  logic       scan_in;
  logic       scan_reset;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int resp_hs = 0;
  logic prev_sclk = 1'b0;
  bit obs_en[$];
  bit obs_in[$];
  bit exp_q[$];
  logic [7:0] pkt [NBytes];

  asc_scan_shifter #(
    .CLKS_PER_SCAN_CLK (Clks),
    .ADDR_BITS         (12),
    .PAYLOAD_BITS      (160),
    .TIMEOUT_CLKS      (Timeout)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data_in        (data_in),
    .response_valid (response_valid),
    .response_ready (response_ready),
    .response_data  (response_data),
    .scan_clk       (scan_clk),
    .scan_en        (scan_en),
    .scan_in        (scan_in),
    .scan_reset     (scan_reset)
  );

  always #5 clk = ~clk;

  // Handshake counters, sampled on the active edge before the DUT updates.
  always @(posedge clk) begin
    if (data_valid && data_ready) hs_cnt <= hs_cnt + 1;
    if (response_valid && response_ready) resp_hs <= resp_hs + 1;
  end

  // Record scan_en/scan_in at every scan_clk rise.
  always @(negedge clk) begin
    if (!prev_sclk && scan_clk) begin
      obs_en.push_back(scan_en);
      obs_in.push_back(scan_in);
    end
    prev_sclk <= scan_clk;
  end

  task automatic push_expected();
    exp_q.delete();
    for (int i = 0; i < NBits; i++) begin
      logic [7:0] b;
      b = pkt[i / 8];
      exp_q.push_back(b[i % 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    data_valid = 1'b1;
    data_in    = b;
    while (!data_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: data_ready=%0b after %0d cycles, want 1", data_ready, n);
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic send_packet();
    for (int k = 0; k < NBytes; k++) send_byte(pkt[k]);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!response_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!response_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_resp: no response_valid within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({scan_clk, scan_en, scan_in, scan_reset} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_scan: got clk/en/in/rst=%b want 0001",
               {scan_clk, scan_en, scan_in, scan_reset});
    end
    checks++;
    if ({response_valid, response_data, data_ready} !== 10'b0) begin
      errors++;
      $display("FAIL reset_resp: got valid=%b data=%h ready=%b want 0 00 0",
               response_valid, response_data, data_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (data_ready !== 1'b1 || scan_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got ready=%b scan_reset=%b want 1 1", data_ready, scan_reset);
    end
    @(negedge clk);
    checks++;
    if (scan_reset !== 1'b0) begin
      errors++;
      $display("FAIL scan_reset_fall: got %b want 0", scan_reset);
    end
  endtask

  task automatic test_full_packet();
    int n_en = 0;
    int n_gap = 0;
    int n = 0;
    int bad = 0;
    logic [7:0] first8;
    foreach (pkt[k]) pkt[k] = 8'h00;
    pkt[0] = 8'h5A;
    obs_en.delete();
    obs_in.delete();
    push_expected();
    response_ready = 1'b1;
    send_packet();
    checks++;
    if (scan_en !== 1'b1) begin
      errors++;
      $display("FAIL shift_latency: scan_en=%b one cycle after last byte, want 1", scan_en);
    end
    while (!response_valid && n < 3000) begin
      if (scan_en) n_en++;
      else n_gap++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n_en != NBits * Clks) begin
      errors++;
      $display("FAIL shift_cycles: got %0d want %0d", n_en, NBits * Clks);
    end
    checks++;
    if (n_gap != 3 * Clks / 2) begin
      errors++;
      $display("FAIL update_cycles: got %0d want %0d", n_gap, 3 * Clks / 2);
    end
    checks++;
    if (response_data !== 8'h01) begin
      errors++;
      $display("FAIL full_resp: got %h want 01", response_data);
    end
    @(negedge clk);
    response_ready = 1'b0;
    checks++;
    if (obs_en.size() != NBits + 1) begin
      errors++;
      $display("FAIL full_rises: got %0d want %0d", obs_en.size(), NBits + 1);
    end
    first8 = 8'h00;
    for (int i = 0; i < 8 && i < obs_in.size(); i++) first8[i] = obs_in[i];
    checks++;
    if (first8 !== 8'h5A) begin
      errors++;
      $display("FAIL full_first8: got %h want 5a (lsb first)", first8);
    end
    for (int i = 0; i < NBits && i < obs_en.size(); i++)
      if (obs_en[i] !== 1'b1 || obs_in[i] !== exp_q[i]) bad++;
    if (obs_en.size() > NBits && obs_en[NBits] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_bits: %0d bad rises, want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    foreach (pkt[k]) pkt[k] = 8'($urandom);
    response_ready = 1'b0;
    send_packet();
    wait_resp(n);
    for (int c = 0; c < 20; c++) begin
      if (response_valid !== 1'b1 || response_data !== 8'h01 || data_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d cycles lost valid/data or raised ready, want 0", bad);
    end
    response_ready = 1'b1;
    @(negedge clk);
    response_ready = 1'b0;
    checks++;
    if (data_ready !== 1'b1 || response_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready=%b valid=%b want 1 0", data_ready, response_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    int bad = 0;
    obs_en.delete();
    obs_in.delete();
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
    wait_resp(n);
    checks++;
    if (n != Timeout) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles want %0d", n, Timeout);
    end
    checks++;
    if (response_data !== 8'hEE) begin
      errors++;
      $display("FAIL timeout_resp: got %h want ee", response_data);
    end
    checks++;
    if (obs_en.size() != 0) begin
      errors++;
      $display("FAIL timeout_sclk: got %0d scan_clk rises want 0", obs_en.size());
    end
    response_ready = 1'b1;
    @(negedge clk);
    foreach (pkt[k]) pkt[k] = 8'($urandom);
    push_expected();
    send_packet();
    wait_resp(n);
    checks++;
    if (response_data !== 8'h01) begin
      errors++;
      $display("FAIL fresh_resp: got %h want 01", response_data);
    end
    @(negedge clk);
    response_ready = 1'b0;
    if (obs_en.size() != NBits + 1) bad++;
    for (int i = 0; i < NBits && i < obs_en.size(); i++)
      if (obs_en[i] !== 1'b1 || obs_in[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fresh_bits: %0d bad rises (count %0d), want 0", bad, obs_en.size());
    end
  endtask

  task automatic test_pad_bits();
    int n;
    int bad = 0;
    logic [3:0] nib;
    foreach (pkt[k]) pkt[k] = 8'h00;
    pkt[NBytes - 1] = 8'hF3;
    obs_en.delete();
    obs_in.delete();
    push_expected();
    response_ready = 1'b1;
    send_packet();
    wait_resp(n);
    @(negedge clk);
    response_ready = 1'b0;
    checks++;
    if (obs_en.size() != NBits + 1) begin
      errors++;
      $display("FAIL pad_rises: got %0d want %0d", obs_en.size(), NBits + 1);
    end
    nib = 4'h0;
    for (int i = 0; i < 4 && (168 + i) < obs_in.size(); i++) nib[i] = obs_in[168 + i];
    checks++;
    if (nib !== 4'h3) begin
      errors++;
      $display("FAIL pad_nibble: bits168..171 got %b want 0011 (msb first)", nib);
    end
    for (int i = 0; i < NBits && i < obs_en.size(); i++)
      if (obs_en[i] !== 1'b1 || obs_in[i] !== exp_q[i]) bad++;
    if (obs_en.size() > NBits && obs_en[NBits] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pad_bits: %0d bad rises want 0", bad);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    int sz;
    int r0;
    foreach (pkt[k]) pkt[k] = 8'($urandom);
    obs_en.delete();
    obs_in.delete();
    response_ready = 1'b1;
    send_packet();
    while (obs_en.size() < 80 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    r0 = resp_hs;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({scan_clk, scan_en, scan_reset} !== 3'b001) begin
      errors++;
      $display("FAIL midreset_outputs: got clk/en/rst=%b want 001", {scan_clk, scan_en, scan_reset});
    end
    sz = obs_en.size();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b want 1", data_ready);
    end
    repeat (800) @(negedge clk);
    checks++;
    if (resp_hs != r0 || obs_en.size() != sz) begin
      errors++;
      $display("FAIL midreset_quiet: responses %0d rises %0d, want 0 0", resp_hs - r0,
               obs_en.size() - sz);
    end
    response_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int hs0;
    foreach (pkt[k]) pkt[k] = 8'($urandom);
    obs_en.delete();
    obs_in.delete();
    hs0 = hs_cnt;
    response_ready = 1'b1;
    send_packet();
    data_valid = 1'b1;
    data_in    = 8'hAB;
    wait_resp(n);
    checks++;
    if (hs_cnt - hs0 != NBytes) begin
      errors++;
      $display("FAIL b2b_hold: got %0d handshakes want %0d", hs_cnt - hs0, NBytes);
    end
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1 right after response", data_ready);
    end
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (hs_cnt - hs0 != NBytes + 1) begin
      errors++;
      $display("FAIL b2b_accept: got %0d handshakes want %0d", hs_cnt - hs0, NBytes + 1);
    end
    checks++;
    if (obs_en.size() != NBits + 1) begin
      errors++;
      $display("FAIL b2b_rises: got %0d want %0d", obs_en.size(), NBits + 1);
    end
    wait_resp(n);
    checks++;
    if (response_data !== 8'hEE) begin
      errors++;
      $display("FAIL b2b_timeout: got %h want ee", response_data);
    end
    @(negedge clk);
    response_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_backpressure();
    test_timeout();
    test_pad_bits();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
